adc_readout_scheduler: RTL

- Sequences one multi-channel ADC capture: gates the ADC sample clock enable, drains the per-channel sample FIFOs round-robin through the shared channel-address mux, and emits channel-tagged samples on a stream port.
- Sits between the AD9228 channel-read block (FIFO side, read clock domain) and the DMA/stream packer.
- After the requested sample count is collected on every channel, it stops sampling, flushes leftover FIFO words and signals done.

---
 rtl/adc_readout_scheduler.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_readout_scheduler.sv
// adc_readout_scheduler
// Runs one multi-channel ADC capture. It enables sampling and drains the
// per-channel FIFOs round-robin through the shared address mux. Each sample
// leaves as a {channel, sample} stream beat. Once every channel has N samples
// it stops sampling, lets the FIFOs settle, flushes leftover words and pulses
// done.
// Optional build macro: ADC_SCHED_TIMEOUT_EN adds a starvation abort after
// TIMEOUT_CYCLES unproductive SELECT cycles. Without it, timeout is tied to 0.
module adc_readout_scheduler #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DATA_WIDTH     = 12,
  parameter int CNT_WIDTH      = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [CNT_WIDTH-1:0]       num_samples,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic                       timeout,
  output logic                       read_en,
  output logic [CW-1:0]              fifo_addr,
  output logic [NUM_CHANNELS-1:0]    fifo_rd_en,
  input  logic                       fifo_not_empty,
  input  logic                       fifo_full,
  input  logic [DATA_WIDTH-1:0]      fifo_dout,
  output logic [CW+DATA_WIDTH-1:0]   m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SELECT, READ, LATCH, OUT, SETTLE, FLUSH, FIN} state_t;

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  n_lat;
  logic [CNT_WIDTH-1:0]  cnt [NUM_CHANNELS];
  logic [SW-1:0]         settle_cnt;
  logic                  flush_wait;
  logic                  sel_hit, last_beat, settle_done, to_expire, addr_last;
  logic [CW-1:0]         addr_next;
  logic [NUM_CHANNELS-1:0] addr_onehot;

  if (NUM_CHANNELS < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("adc_readout_scheduler: NUM_CHANNELS, SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  // Counters stop at the requested length so a stray extra beat can never overrun N.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val,
                                                   input logic [CNT_WIDTH-1:0] lim);
    return (val < lim) ? val + 1'b1 : val;
  endfunction

  assign addr_last   = (fifo_addr == CW'(NUM_CHANNELS - 1));
  assign addr_next   = addr_last ? '0 : fifo_addr + 1'b1;
  assign addr_onehot = NUM_CHANNELS'(1) << fifo_addr;
  assign sel_hit     = (cnt[fifo_addr] < n_lat) && fifo_not_empty;
  assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign busy        = (state != IDLE) && (state != FIN);

  // Detect the beat on the selected channel that completes the whole capture.
  always_comb begin
    last_beat = 1'b1;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (CW'(i) == fifo_addr) begin
        if (cnt[i] + 1'b1 != n_lat) last_beat = 1'b0;
      end else if (cnt[i] != n_lat) begin
        last_beat = 1'b0;
      end
    end
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign to_expire = !sel_hit && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count unproductive SELECT cycles since the last read and flag starvation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (state == IDLE && start) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (state == SELECT) begin
      if (sel_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
        if (to_expire) timeout <= 1'b1;
      end
    end
  end
`else
  assign to_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode plus the combinational strobes (read pulse, done).
  always_comb begin
    state_next = state;
    fifo_rd_en = '0;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = (num_samples == '0) ? FIN : SELECT;
      SELECT:  begin
        if (sel_hit)        state_next = READ;
        else if (to_expire) state_next = SETTLE;
      end
      READ:    begin
        fifo_rd_en = addr_onehot;
        state_next = LATCH;
      end
      LATCH:   state_next = OUT;
      OUT:     if (m_tready) state_next = last_beat ? SETTLE : SELECT;
      SETTLE:  if (settle_done) state_next = FLUSH;
      FLUSH:   begin
        if (!flush_wait) begin
          if (fifo_not_empty) fifo_rd_en = addr_onehot;
          else if (addr_last) state_next = FIN;
        end
      end
      FIN:     begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Requested length is captured on the accepted start and only read while busy.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) n_lat <= num_samples;
  end

  // Channel pointer, per-channel counters, sampling enable, stream register, settle/flush pacing.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CHANNELS; i++) cnt[i] <= '0;
      fifo_addr  <= '0;
      read_en    <= 1'b0;
      overflow   <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      settle_cnt <= '0;
      flush_wait <= 1'b0;
    end else begin
      if (read_en && fifo_full) overflow <= 1'b1;
      case (state)
        IDLE:    if (start) begin
          overflow <= 1'b0;
          if (num_samples != '0) begin
            for (int i = 0; i < NUM_CHANNELS; i++) cnt[i] <= '0;
            fifo_addr <= '0;
            read_en   <= 1'b1;
          end
        end
        SELECT:  if (!sel_hit) begin
          if (to_expire) read_en   <= 1'b0;
          else           fifo_addr <= addr_next;
        end
        LATCH:   begin
          m_tdata  <= {fifo_addr, fifo_dout};
          m_tvalid <= 1'b1;
          m_tlast  <= last_beat;
        end
        OUT:     if (m_tready) begin
          cnt[fifo_addr] <= sat_inc(cnt[fifo_addr], n_lat);
          fifo_addr      <= addr_next;
          m_tvalid       <= 1'b0;
          m_tlast        <= 1'b0;
          if (last_beat) read_en <= 1'b0;
        end
        SETTLE:  begin
          if (settle_done) begin
            settle_cnt <= '0;
            fifo_addr  <= '0;
            flush_wait <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        FLUSH:   begin
          if (flush_wait)          flush_wait <= 1'b0;
          else if (fifo_not_empty) flush_wait <= 1'b1;
          else if (!addr_last)     fifo_addr  <= addr_next;
        end
        default: ;
      endcase
    end
  end

endmodule
